// File: rtl/fft_out_reorder_pkg.sv
// Shared constants, state encodings and the bit-reversal helper for the FFT output reorder buffer.
// N must be a power of two >= 8; the 4 lanes are fixed.
package fft_out_reorder_pkg;

  localparam int N     = 128;
  localparam int LOGN  = 7;
  localparam int LANES = 4;
  localparam int DW    = 30;
  localparam int BEATS = N / LANES;
  localparam int BW    = LOGN - 2;

  typedef enum logic [1:0] {
    BANK_EMPTY,
    BANK_FILL,
    BANK_FULL,
    BANK_DRAIN
  } bank_state_e;

  typedef enum logic {
    WIDLE,
    WFILL
  } wr_state_e;

  typedef enum logic {
    RIDLE,
    RDRAIN
  } rd_state_e;

  function automatic logic [LOGN-1:0] bitrev(input logic [LOGN-1:0] k);
    logic [LOGN-1:0] r;
    r = '0;
    for (int i = 0; i < LOGN; i++) begin
      r[i] = k[LOGN-1-i];
    end
    return r;
  endfunction

endpackage

// File: rtl/fft_out_reorder_if.sv
// Bin stream into the reorder buffer (no backpressure) and natural-order stream out (valid/ready).
// master = surrounding datapath/consumer, slave = the reorder buffer.
interface fft_out_reorder_if;

  logic                                                           in_valid;
  logic                                                           in_sof;
  logic [fft_out_reorder_pkg::LANES*fft_out_reorder_pkg::DW-1:0]  in_data;
  logic                                                           out_valid;
  logic                                                           out_ready;
  logic                                                           out_sof;
  logic                                                           out_eof;
  logic [fft_out_reorder_pkg::LANES*fft_out_reorder_pkg::DW-1:0]  out_data;

  modport master (
    output in_valid, in_sof, in_data, out_ready,
    input  out_valid, out_sof, out_eof, out_data
  );

  modport slave (
    input  in_valid, in_sof, in_data, out_ready,
    output out_valid, out_sof, out_eof, out_data
  );

endinterface

// File: rtl/fft_out_reorder_bank.sv
// One N-bin frame buffer: 4 bit-reversed scattered writes per beat, 4 contiguous reads per beat.
// Read is combinational with write-through forwarding so a drain can start on the sealing cycle.
module fft_out_reorder_bank
  import fft_out_reorder_pkg::*;
(
  input  logic                  clk,
  input  logic                  we_i,
  input  logic [BW-1:0]         wbeat_i,
  input  logic [LANES*DW-1:0]   wdata_i,
  input  logic [BW-1:0]         rbeat_i,
  output logic [LANES*DW-1:0]   rdata_o
);

  logic [DW-1:0] mem_q [N];

  always_ff @(posedge clk) begin
    if (we_i) begin
      for (int l = 0; l < LANES; l++) begin
        mem_q[bitrev({wbeat_i, 2'(l)})] <= wdata_i[l*DW +: DW];
      end
    end
  end

  always_comb begin
    logic [LOGN-1:0] raddr;
    raddr   = '0;
    rdata_o = '0;
    for (int l = 0; l < LANES; l++) begin
      raddr = {rbeat_i, 2'(l)};
      rdata_o[l*DW +: DW] = mem_q[raddr];
      // Bin being written this very cycle wins over the stale array entry.
      for (int j = 0; j < LANES; j++) begin
        if (we_i && (bitrev({wbeat_i, 2'(j)}) == raddr)) begin
          rdata_o[l*DW +: DW] = wdata_i[j*DW +: DW];
        end
      end
    end
  end

endmodule

// File: rtl/fft_out_reorder.sv
// Ping-pong reorder of bit-reversed FFT output into natural order, 4 bins per beat.
// First out beat one clock after the sealing input beat; output stalls on out_ready=0, input never stalls (drops + overflow).
module fft_out_reorder
  import fft_out_reorder_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  fft_out_reorder_if.slave  bus,
  output logic              overflow_o,
  output logic              frame_err_o
);

  wr_state_e            wstate_q, wstate_d;
  logic                 wptr_q, wptr_d;
  logic [BW-1:0]        wbeat_q, wbeat_d;
  logic [BW-1:0]        wbeat_sel;

  rd_state_e            rstate_q, rstate_d;
  logic                 rptr_q, rptr_d;
  logic [BW-1:0]        rbeat_q, rbeat_d;
  logic                 rsel;
  logic                 load;

  bank_state_e          bank_q [2];
  bank_state_e          bank_d [2];

  logic [1:0]           we, seal, start_w, free, rd_start, ready_bank;
  logic                 adv;

  logic                 out_valid_q, out_valid_d;
  logic                 out_sof_q, out_sof_d;
  logic                 out_eof_q, out_eof_d;
  logic [LANES*DW-1:0]  out_data_q, out_data_d;
  logic                 overflow_q, overflow_d;
  logic                 frame_err_q, frame_err_d;
  logic [LANES*DW-1:0]  rd_dat [2];

  for (genvar g = 0; g < 2; g++) begin : g_bank
    fft_out_reorder_bank u_bank (
      .clk     (clk),
      .we_i    (we[g]),
      .wbeat_i (wbeat_sel),
      .wdata_i (bus.in_data),
      .rbeat_i (rbeat_d),
      .rdata_o (rd_dat[g])
    );
  end

  assign adv = out_valid_q & bus.out_ready;

  always_comb begin
    wstate_d    = wstate_q;
    wptr_d      = wptr_q;
    wbeat_d     = wbeat_q;
    wbeat_sel   = wbeat_q;
    rstate_d    = rstate_q;
    rptr_d      = rptr_q;
    rbeat_d     = rbeat_q;
    rsel        = rptr_q;
    load        = 1'b0;
    we          = '0;
    seal        = '0;
    start_w     = '0;
    free        = '0;
    rd_start    = '0;
    ready_bank  = '0;
    overflow_d  = overflow_q;
    frame_err_d = frame_err_q;
    out_valid_d = out_valid_q;
    out_sof_d   = out_sof_q;
    out_eof_d   = out_eof_q;
    out_data_d  = out_data_q;
    bank_d      = bank_q;

    // Free first so an sof in the eof-handshake cycle can claim the bank.
    if (adv && out_eof_q) begin
      free[rptr_q] = 1'b1;
    end

    if (bus.in_valid) begin
      if (bus.in_sof) begin
        if (wstate_q == WFILL) begin
          we[wptr_q]  = 1'b1;
          wbeat_sel   = '0;
          wbeat_d     = BW'(1);
          frame_err_d = 1'b1;
        end else if ((bank_q[wptr_q] == BANK_EMPTY) || free[wptr_q]) begin
          we[wptr_q]      = 1'b1;
          start_w[wptr_q] = 1'b1;
          wbeat_sel       = '0;
          wbeat_d         = BW'(1);
          wstate_d        = WFILL;
        end else begin
          overflow_d = 1'b1;
        end
      end else if (wstate_q == WFILL) begin
        we[wptr_q] = 1'b1;
        wbeat_d    = wbeat_q + BW'(1);
        if (wbeat_q == BW'(BEATS-1)) begin
          seal[wptr_q] = 1'b1;
          wstate_d     = WIDLE;
          wptr_d       = ~wptr_q;
        end
      end
    end

    for (int b = 0; b < 2; b++) begin
      ready_bank[b] = (bank_q[b] == BANK_FULL) || seal[b];
    end

    if (rstate_q == RIDLE) begin
      if (ready_bank[rptr_q]) begin
        rd_start[rptr_q] = 1'b1;
        load             = 1'b1;
        rbeat_d          = '0;
        rstate_d         = RDRAIN;
      end
    end else if (adv) begin
      if (!out_eof_q) begin
        load    = 1'b1;
        rbeat_d = rbeat_q + BW'(1);
      end else begin
        rptr_d = ~rptr_q;
        rsel   = ~rptr_q;
        if (ready_bank[~rptr_q]) begin
          rd_start[~rptr_q] = 1'b1;
          load              = 1'b1;
          rbeat_d           = '0;
        end else begin
          rstate_d = RIDLE;
        end
      end
    end

    if (load) begin
      out_valid_d = 1'b1;
      out_sof_d   = (rbeat_d == '0);
      out_eof_d   = (rbeat_d == BW'(BEATS-1));
      out_data_d  = rsel ? rd_dat[1] : rd_dat[0];
    end else if (rstate_d == RIDLE) begin
      out_valid_d = 1'b0;
      out_sof_d   = 1'b0;
      out_eof_d   = 1'b0;
    end

    // Later events in the cycle override earlier ones; seal+start in one cycle lands in DRAIN.
    for (int b = 0; b < 2; b++) begin
      if (free[b])     bank_d[b] = BANK_EMPTY;
      if (start_w[b])  bank_d[b] = BANK_FILL;
      if (seal[b])     bank_d[b] = BANK_FULL;
      if (rd_start[b]) bank_d[b] = BANK_DRAIN;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wstate_q    <= WIDLE;
      wptr_q      <= 1'b0;
      wbeat_q     <= '0;
      rstate_q    <= RIDLE;
      rptr_q      <= 1'b0;
      rbeat_q     <= '0;
      bank_q[0]   <= BANK_EMPTY;
      bank_q[1]   <= BANK_EMPTY;
      out_valid_q <= 1'b0;
      out_sof_q   <= 1'b0;
      out_eof_q   <= 1'b0;
      out_data_q  <= '0;
      overflow_q  <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      wstate_q    <= wstate_d;
      wptr_q      <= wptr_d;
      wbeat_q     <= wbeat_d;
      rstate_q    <= rstate_d;
      rptr_q      <= rptr_d;
      rbeat_q     <= rbeat_d;
      bank_q      <= bank_d;
      out_valid_q <= out_valid_d;
      out_sof_q   <= out_sof_d;
      out_eof_q   <= out_eof_d;
      out_data_q  <= out_data_d;
      overflow_q  <= overflow_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_sof   = out_sof_q;
  assign bus.out_eof   = out_eof_q;
  assign bus.out_data  = out_data_q;
  assign overflow_o    = overflow_q;
  assign frame_err_o   = frame_err_q;

endmodule

// File: tb/tb_fft_out_reorder.sv
// Directed bench for the FFT output reorder buffer; bins are tagged {frame id, natural bin index}.
module tb_fft_out_reorder;
  import fft_out_reorder_pkg::*;

  logic clk;
  logic rst_n;
  logic overflow;
  logic frame_err;

  fft_out_reorder_if ifc ();

  fft_out_reorder dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (ifc),
    .overflow_o  (overflow),
    .frame_err_o (frame_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int mb       = 0;
  int first_acc = -1;
  int last_acc  = -1;
  bit bp       = 1'b0;
  int exp_q [$];

  function automatic int tb_bitrev(int k);
    int r = 0;
    for (int i = 0; i < LOGN; i++) r = (r << 1) | ((k >> i) & 1);
    return r;
  endfunction

  function automatic logic [DW-1:0] bin_val(int f, int n);
    return {15'(f), 15'(n)};
  endfunction

  function automatic logic [LANES*DW-1:0] in_beat(int f, int b);
    logic [LANES*DW-1:0] v = '0;
    for (int l = 0; l < LANES; l++) v[l*DW +: DW] = bin_val(f, tb_bitrev(4*b + l));
    return v;
  endfunction

  function automatic logic [LANES*DW-1:0] out_beat(int f, int r);
    logic [LANES*DW-1:0] v = '0;
    for (int l = 0; l < LANES; l++) v[l*DW +: DW] = bin_val(f, 4*r + l);
    return v;
  endfunction

  task automatic chk1(string tag, logic obs, logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chkd(string tag, logic [LANES*DW-1:0] obs, logic [LANES*DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Negedge: check the presented beat; posedge+1: state after the edge, inputs may change.
  task automatic tick();
    @(negedge clk);
    if (ifc.out_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk1("unexpected_beat", ifc.out_valid, 1'b0);
      end else begin
        chkd("out_data", ifc.out_data, out_beat(exp_q[0], mb));
        chk1("out_sof", ifc.out_sof, logic'(mb == 0));
        chk1("out_eof", ifc.out_eof, logic'(mb == BEATS-1));
        if (ifc.out_ready === 1'b1) begin
          if (first_acc < 0) first_acc = cyc;
          last_acc = cyc;
          mb++;
          if (mb == BEATS) begin
            mb = 0;
            void'(exp_q.pop_front());
          end
        end
      end
    end
    @(posedge clk);
    #1;
    cyc++;
    if (bp) ifc.out_ready = ~ifc.out_ready;
  endtask

  task automatic send_beats(int f, int b0, int b1);
    for (int b = b0; b <= b1; b++) begin
      ifc.in_valid = 1'b1;
      ifc.in_sof   = (b == 0);
      ifc.in_data  = in_beat(f, b);
      tick();
    end
    ifc.in_valid = 1'b0;
    ifc.in_sof   = 1'b0;
  endtask

  task automatic drain(string tag, int budget);
    int g = 0;
    while (exp_q.size() != 0 && g < budget) begin
      tick();
      g++;
    end
    chk1(tag, logic'(exp_q.size() == 0), 1'b1);
  endtask

  initial begin
    int g;
    rst_n         = 1'b0;
    ifc.in_valid  = 1'b0;
    ifc.in_sof    = 1'b0;
    ifc.in_data   = '0;
    ifc.out_ready = 1'b1;
    #12;
    chk1("rst_out_valid", ifc.out_valid, 1'b0);
    chk1("rst_out_sof", ifc.out_sof, 1'b0);
    chk1("rst_out_eof", ifc.out_eof, 1'b0);
    chkd("rst_out_data", ifc.out_data, '0);
    chk1("rst_overflow", overflow, 1'b0);
    chk1("rst_frame_err", frame_err, 1'b0);
    rst_n = 1'b1;
    tick();

    // Stray beat without sof is ignored.
    ifc.in_valid = 1'b1;
    ifc.in_data  = in_beat(99, 3);
    tick();
    ifc.in_valid = 1'b0;
    tick();
    chk1("stray_no_valid", ifc.out_valid, 1'b0);

    // Single frame, latency to first beat.
    exp_q.push_back(1);
    send_beats(1, 0, BEATS-2);
    chk1("lat_before_seal", ifc.out_valid, 1'b0);
    send_beats(1, BEATS-1, BEATS-1);
    chk1("lat_valid", ifc.out_valid, 1'b1);
    chk1("lat_sof", ifc.out_sof, 1'b1);
    drain("drain_single", 200);

    // Four frames back to back.
    first_acc = -1;
    for (int f = 2; f <= 5; f++) exp_q.push_back(f);
    for (int f = 2; f <= 5; f++) send_beats(f, 0, BEATS-1);
    drain("drain_b2b", 200);
    chk1("b2b_span", logic'((last_acc - first_acc) <= 4*BEATS - 1 + 3), 1'b1);
    chk1("b2b_overflow", overflow, 1'b0);

    // Backpressure toggling every cycle.
    exp_q.push_back(6);
    bp = 1'b1;
    send_beats(6, 0, BEATS-1);
    drain("drain_bp", 300);
    bp = 1'b0;
    ifc.out_ready = 1'b1;
    tick();

    // Overflow: consumer stalled, third frame dropped.
    ifc.out_ready = 1'b0;
    exp_q.push_back(7);
    exp_q.push_back(8);
    send_beats(7, 0, BEATS-1);
    send_beats(8, 0, BEATS-1);
    chk1("ovf_before", overflow, 1'b0);
    send_beats(9, 0, BEATS-1);
    chk1("ovf_set", overflow, 1'b1);
    chk1("ovf_stall_valid", ifc.out_valid, 1'b1);
    ifc.out_ready = 1'b1;
    drain("drain_ovf", 300);
    for (int i = 0; i < 10; i++) tick();
    chk1("ovf_no_third", ifc.out_valid, 1'b0);

    // Mid-frame sof restarts the bank.
    chk1("ferr_before", frame_err, 1'b0);
    exp_q.push_back(11);
    send_beats(10, 0, 9);
    send_beats(11, 0, BEATS-1);
    chk1("ferr_set", frame_err, 1'b1);
    drain("drain_ferr", 200);

    // Async reset in the middle of a drain.
    exp_q.push_back(12);
    send_beats(12, 0, BEATS-1);
    g = 0;
    while (mb != 15 && g < 100) begin
      tick();
      g++;
    end
    chk1("arst_reached_beat15", logic'(mb == 15), 1'b1);
    #3;
    rst_n = 1'b0;
    #2;
    chk1("arst_out_valid", ifc.out_valid, 1'b0);
    chk1("arst_out_sof", ifc.out_sof, 1'b0);
    chk1("arst_overflow", overflow, 1'b0);
    chk1("arst_frame_err", frame_err, 1'b0);
    chkd("arst_out_data", ifc.out_data, '0);
    exp_q.delete();
    mb = 0;
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    tick();
    exp_q.push_back(13);
    send_beats(13, 0, BEATS-1);
    drain("drain_after_rst", 200);
    chk1("final_idle", ifc.out_valid, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
